// File: rtl/uart_pkg.sv
// Shared definitions for the byte UART transmitter.
// State encoding, default baud divider and frame size.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    localparam int unsigned CLK_DIV_DEF = 434;
    localparam int unsigned FRAME_BITS  = 10;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with clock enable and occupancy count.
// Push while full is accepted only when a pop frees a slot on the same edge.
module byte_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ce,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [7:0]                 data_i,
    output logic [7:0]                 data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [LW-1:0] cnt_q;
    logic [LW-1:0] cnt_d;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == LW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign level_o = cnt_q;
    assign data_o  = mem_q[rd_q];

    assign do_pop  = ce & pop_i & ~empty_o;
    assign do_push = ce & push_i & (~full_o | do_pop);

    always_comb begin
        cnt_d = cnt_q;
        unique case (1'b1)
            do_push & ~do_pop: cnt_d = cnt_q + LW'(1);
            do_pop & ~do_push: cnt_d = cnt_q - LW'(1);
            default:           cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/byte_uart_tx.sv
// UART 8N1 transmitter with input byte FIFO, LSB first.
// Frames run back-to-back while the FIFO holds data.
module byte_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV    = CLK_DIV_DEF,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ce,
    input  logic                            byte_dv,
    input  logic [7:0]                      byte_data,
    output logic                            tx,
    output logic                            busy,
    output logic                            overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

    localparam int unsigned CW = $clog2(CLK_DIV);

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
    logic          tx_q;
    logic          ovf_q;
    logic          ovf_d;

    logic          cnt_end;
    logic          pop;
    logic          full;
    logic          empty;
    logic [7:0]    fifo_dout;

    assign cnt_end = (cnt_q == CW'(CLK_DIV - 1));

    assign pop = ce & ~empty &
                 ((state_q == IDLE) |
                  ((state_q == STOP) & cnt_end));

    assign ovf_d = ce & byte_dv & full & ~pop;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .ce      (ce),
        .push_i  (byte_dv),
        .pop_i   (pop),
        .data_i  (byte_data),
        .data_o  (fifo_dout),
        .full_o  (full),
        .empty_o (empty),
        .level_o (fifo_level)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            if (ce) begin
                unique case (state_q)
                    IDLE: begin
                        tx_q <= 1'b1;
                        if (!empty) begin
                            shift_q <= fifo_dout;
                            cnt_q   <= '0;
                            state_q <= START;
                            tx_q    <= 1'b0;
                        end
                    end
                    START: begin
                        if (cnt_end) begin
                            cnt_q   <= '0;
                            idx_q   <= '0;
                            state_q <= DATA;
                            tx_q    <= shift_q[0];
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    DATA: begin
                        if (cnt_end) begin
                            cnt_q   <= '0;
                            shift_q <= shift_q >> 1;
                            if (idx_q == 3'd7) begin
                                state_q <= STOP;
                                tx_q    <= 1'b1;
                            end else begin
                                idx_q <= idx_q + 3'd1;
                                tx_q  <= shift_q[1];
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    STOP: begin
                        if (cnt_end) begin
                            cnt_q <= '0;
                            if (!empty) begin
                                shift_q <= fifo_dout;
                                state_q <= START;
                                tx_q    <= 1'b0;
                            end else begin
                                state_q <= IDLE;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        tx_q    <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign tx       = tx_q;
    assign overflow = ovf_q;
    assign busy     = (state_q != IDLE) | (fifo_level != '0);

endmodule

// File: tb/tb_byte_uart_tx.sv
// Directed bench for byte_uart_tx with CLK_DIV=4, FIFO_DEPTH=4.
// Frames are checked bit by bit on every clock of every bit.
module tb_byte_uart_tx;
    import uart_pkg::*;

    localparam int DIV = 4;
    localparam int DEP = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ce = 1'b1;
    logic       byte_dv = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       tx;
    logic       busy;
    logic       overflow;
    logic [2:0] fifo_level;

    int         n_chk = 0;
    int         n_pass = 0;
    int         ovf_at = -1;
    logic [7:0] pend[$];

    byte_uart_tx #(
        .CLK_DIV    (DIV),
        .FIFO_DEPTH (DEP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .byte_dv    (byte_dv),
        .byte_data  (byte_data),
        .tx         (tx),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input string tag,
                         input logic [7:0] b,
                         input bit tog);
        logic [9:0] bits;
        int len;
        int n;
        bits = {1'b1, b, 1'b0};
        len = tog ? 2 * DIV : DIV;
        n = 0;
        for (int i = 0; i < FRAME_BITS; i++) begin
            for (int c = 0; c < len; c++) begin
                check($sformatf("%s_b%0d_c%0d", tag, i, c),
                      32'(tx), 32'(bits[i]));
                check($sformatf("%s_ovf%0d", tag, n),
                      32'(overflow), 32'(n == ovf_at));
                if (pend.size() > 0) begin
                    byte_dv = 1'b1;
                    byte_data = pend.pop_front();
                end else begin
                    byte_dv = 1'b0;
                end
                if (tog) begin
                    ce = (c % 2 == 1);
                    if (i == 3 && c == 0) begin
                        byte_dv = 1'b1;
                        byte_data = 8'h77;
                    end
                    if (i == 3 && c == 2)
                        check({tag, "_lvl"}, 32'(fifo_level), 0);
                end
                step();
                n++;
            end
        end
        byte_dv = 1'b0;
        ce = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) step();
        check("rst_tx", 32'(tx), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_lvl", 32'(fifo_level), 0);
        rst = 1'b1;
        step();
        check("rel_tx", 32'(tx), 1);
        check("rel_busy", 32'(busy), 0);
        check("rel_lvl", 32'(fifo_level), 0);
        check("rel_ovf", 32'(overflow), 0);

        byte_dv = 1'b1;
        byte_data = 8'hA5;
        step();
        byte_dv = 1'b0;
        check("a5_pre_tx", 32'(tx), 1);
        check("a5_pre_lvl", 32'(fifo_level), 1);
        check("a5_pre_busy", 32'(busy), 1);
        step();
        check("a5_pop_lvl", 32'(fifo_level), 0);
        frame("a5", 8'hA5, 1'b0);
        check("a5_busy_end", 32'(busy), 0);
        check("a5_tx_end", 32'(tx), 1);

        byte_dv = 1'b1;
        byte_data = 8'h34;
        step();
        byte_data = 8'h12;
        step();
        byte_dv = 1'b0;
        check("pair_lvl", 32'(fifo_level), 1);
        frame("p34", 8'h34, 1'b0);
        check("pair_lvl2", 32'(fifo_level), 0);
        frame("p12", 8'h12, 1'b0);
        check("pair_busy", 32'(busy), 0);

        byte_dv = 1'b1;
        byte_data = 8'h01;
        step();
        byte_data = 8'h02;
        step();
        pend = '{8'h03, 8'h04, 8'h05, 8'h06};
        ovf_at = 4;
        frame("s1", 8'h01, 1'b0);
        ovf_at = -1;
        check("six_lvl", 32'(fifo_level), 3);
        frame("s2", 8'h02, 1'b0);
        frame("s3", 8'h03, 1'b0);
        frame("s4", 8'h04, 1'b0);
        frame("s5", 8'h05, 1'b0);
        check("six_busy", 32'(busy), 0);
        check("six_lvl_end", 32'(fifo_level), 0);
        check("six_tx_end", 32'(tx), 1);

        byte_dv = 1'b1;
        byte_data = 8'h5A;
        step();
        byte_dv = 1'b0;
        step();
        frame("ce", 8'h5A, 1'b1);
        check("ce_busy", 32'(busy), 0);
        check("ce_lvl", 32'(fifo_level), 0);

        byte_dv = 1'b1;
        byte_data = 8'hFF;
        step();
        step();
        byte_dv = 1'b0;
        repeat (10) step();
        check("ff_mid_lvl", 32'(fifo_level), 1);
        check("ff_mid_busy", 32'(busy), 1);
        #2;
        rst = 1'b0;
        #1;
        check("ff_rst_tx", 32'(tx), 1);
        check("ff_rst_busy", 32'(busy), 0);
        check("ff_rst_lvl", 32'(fifo_level), 0);
        step();
        step();
        rst = 1'b1;
        repeat (6) step();
        check("ff_post_tx", 32'(tx), 1);
        check("ff_post_busy", 32'(busy), 0);
        check("ff_post_lvl", 32'(fifo_level), 0);

        byte_dv = 1'b1;
        byte_data = 8'h00;
        step();
        byte_dv = 1'b0;
        step();
        frame("z", 8'h00, 1'b0);
        check("z_busy", 32'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
